// File: rtl/prbs_tx_gen_if.sv
// rtl/prbs_tx_gen_if.sv - control and TX word bundle for the PRBS-7 lane generator
interface prbs_tx_gen_if;
    logic        enable;
    logic        inject;
    logic [15:0] tx_data;
    logic [1:0]  tx_charisk;
    logic [1:0]  state_status;
    logic [7:0]  inj_count;
    logic        inject_pending;

    modport master (
        input  enable,
        input  inject,
        output tx_data,
        output tx_charisk,
        output state_status,
        output inj_count,
        output inject_pending
    );

    modport slave (
        output enable,
        output inject,
        input  tx_data,
        input  tx_charisk,
        input  state_status,
        input  inj_count,
        input  inject_pending
    );
endinterface

// File: rtl/prbs_tx_gen.sv
// rtl/prbs_tx_gen.sv - PRBS-7 GTX TX pattern generator with comma alignment and error injection
module prbs_tx_gen #(
    parameter int unsigned ALIGN_WORDS  = 64,
    parameter int unsigned COMMA_PERIOD = 1024,
    parameter logic [15:0] COMMA_WORD   = 16'h50BC
) (
    input  logic          txusrclk2,
    input  logic          reset_n,
    prbs_tx_gen_if.master bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ALIGN = 2'b01,
        RUN   = 2'b10
    } state_t;

    localparam logic [7:0]  ALIGN_LAST = 8'(ALIGN_WORDS - 1);
    localparam logic [15:0] PERIOD     = 16'(COMMA_PERIOD);

    state_t      state, state_nx;
    logic [7:0]  align_cnt, align_cnt_nx;
    logic [15:0] run_cnt, run_cnt_nx;
    logic [6:0]  lfsr, lfsr_nx;
    logic [15:0] data_q, data_nx;
    logic [1:0]  charisk_q, charisk_nx;
    logic [7:0]  inj_cnt_q, inj_cnt_nx;
    logic        pending_q, pending_nx;
    logic        apply;
    logic [2:0]  inj_sync;
    logic        inj_edge;
    logic [22:0] prbs_ext;

    // lfsr holds b[n..n+6]; 16 more serial steps give the word plus the following seed
    function automatic logic [22:0] prbs_expand(input logic [6:0] seed);
        logic [22:0] ext;
        ext      = '0;
        ext[6:0] = seed;
        for (int i = 7; i < 23; i++) begin
            ext[i] = ext[i-6] ^ ext[i-7];
        end
        return ext;
    endfunction

    assign prbs_ext = prbs_expand(lfsr);
    assign inj_edge = inj_sync[1] & ~inj_sync[2];

    // two-flop synchronizer for the VIO inject level plus a history flop for edge detection
    always_ff @(posedge txusrclk2 or negedge reset_n) begin
        if (!reset_n) begin
            inj_sync <= '0;
        end else begin
            inj_sync <= {inj_sync[1:0], bus.inject};
        end
    end

    // state register; the outputs are registered alongside so they line up with state_status
    always_ff @(posedge txusrclk2 or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            align_cnt <= '0;
            run_cnt   <= '0;
            lfsr      <= 7'h7F;
            data_q    <= '0;
            charisk_q <= '0;
            inj_cnt_q <= '0;
            pending_q <= 1'b0;
        end else begin
            state     <= state_nx;
            align_cnt <= align_cnt_nx;
            run_cnt   <= run_cnt_nx;
            lfsr      <= lfsr_nx;
            data_q    <= data_nx;
            charisk_q <= charisk_nx;
            inj_cnt_q <= inj_cnt_nx;
            pending_q <= pending_nx;
        end
    end

    // next state: enable low always returns to IDLE, ALIGN lasts exactly ALIGN_WORDS words
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (bus.enable) state_nx = ALIGN;
            ALIGN:   if (!bus.enable) state_nx = IDLE;
                     else if (align_cnt == ALIGN_LAST) state_nx = RUN;
            RUN:     if (!bus.enable) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // word for the state being entered; the LFSR only advances on PRBS words so commas do not break the sequence
    always_comb begin
        align_cnt_nx = '0;
        run_cnt_nx   = '0;
        lfsr_nx      = lfsr;
        data_nx      = '0;
        charisk_nx   = 2'b00;
        apply        = 1'b0;
        unique case (state_nx)
            ALIGN: begin
                data_nx      = COMMA_WORD;
                charisk_nx   = 2'b01;
                lfsr_nx      = 7'h7F;
                align_cnt_nx = (state == ALIGN) ? align_cnt + 8'd1 : 8'd0;
            end
            RUN: begin
                if (state == RUN && run_cnt == PERIOD) begin
                    data_nx    = COMMA_WORD;
                    charisk_nx = 2'b01;
                end else begin
                    data_nx    = prbs_ext[15:0] ^ {15'd0, pending_q};
                    apply      = pending_q;
                    lfsr_nx    = prbs_ext[22:16];
                    run_cnt_nx = run_cnt + 16'd1;
                end
            end
            default: begin
                data_nx = '0;
            end
        endcase
        // an edge seen on the same cycle a request is consumed becomes a fresh request
        pending_nx = inj_edge | (pending_q & ~apply);
        inj_cnt_nx = inj_cnt_q + {7'd0, apply};
    end

    assign bus.tx_data        = data_q;
    assign bus.tx_charisk     = charisk_q;
    assign bus.state_status   = state;
    assign bus.inj_count      = inj_cnt_q;
    assign bus.inject_pending = pending_q;
endmodule

// File: tb/tb_prbs_tx_gen.sv
// tb/tb_prbs_tx_gen.sv - scoreboard bench for prbs_tx_gen against a serial PRBS-7 model
module tb_prbs_tx_gen;
    localparam int          AW     = 4;
    localparam int          CP     = 4;
    localparam logic [15:0] COMMA  = 16'h50BC;
    localparam int          NWORDS = 2200;

    typedef struct packed {
        logic [15:0] data;
        logic [1:0]  k;
        logic [1:0]  st;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    prbs_tx_gen_if bus ();

    prbs_tx_gen #(
        .ALIGN_WORDS (AW),
        .COMMA_PERIOD(CP),
        .COMMA_WORD  (COMMA)
    ) dut (
        .txusrclk2(clk),
        .reset_n  (reset_n),
        .bus      (bus)
    );

    exp_t       exp_q[$];
    bit         prbs_bits[0:16*NWORDS-1];
    int         total = 0;
    int         bad   = 0;
    logic [7:0] exp_inj = 8'd0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input logic [15:0] d, input logic [1:0] k, input logic [1:0] s);
        exp_t e;
        e.data = d;
        e.k    = k;
        e.st   = s;
        return e;
    endfunction

    function automatic logic [15:0] model_word(input int w);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) r[i] = prbs_bits[16*w+i];
        return r;
    endfunction

    task automatic push_idle(input int n);
        repeat (n) exp_q.push_back(mk(16'h0000, 2'b00, 2'b00));
    endtask

    task automatic push_stream(input int n_run);
        int w;
        int c;
        w = 0;
        c = 0;
        for (int i = 0; i < AW; i++) exp_q.push_back(mk(COMMA, 2'b01, 2'b01));
        for (int j = 0; j < n_run; j++) begin
            if (c == CP) begin
                exp_q.push_back(mk(COMMA, 2'b01, 2'b10));
                c = 0;
            end else begin
                exp_q.push_back(mk(model_word(w), 2'b00, 2'b10));
                w++;
                c++;
            end
        end
    endtask

    task automatic mark_inject(input int from);
        exp_t e;
        bit   done;
        done = 1'b0;
        for (int i = from; i < exp_q.size() && !done; i++) begin
            e = exp_q[i];
            if (e.k == 2'b00 && e.st == 2'b10) begin
                e.data[0] = ~e.data[0];
                exp_q[i]  = e;
                exp_inj   = exp_inj + 8'd1;
                done      = 1'b1;
            end
        end
    endtask

    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (exp_q.size() == 0) begin
            check("sb_depth", 0, 1);
        end else begin
            e = exp_q.pop_front();
            check("tx_data", bus.tx_data, e.data);
            check("tx_charisk", bus.tx_charisk, e.k);
            check("state_status", bus.state_status, e.st);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.enable = 1'b0;
        bus.inject = 1'b0;
        reset_n    = 1'b0;
        for (int i = 0; i < 16*NWORDS; i++) begin
            prbs_bits[i] = (i < 7) ? 1'b1 : (prbs_bits[i-6] ^ prbs_bits[i-7]);
        end

        repeat (2) @(negedge clk);
        check("rst_data", bus.tx_data, 16'h0000);
        check("rst_charisk", bus.tx_charisk, 2'b00);
        check("rst_status", bus.state_status, 2'b00);
        check("rst_inj_count", bus.inj_count, 8'd0);
        check("rst_pending", bus.inject_pending, 1'b0);

        reset_n = 1'b1;
        push_idle(2);
        repeat (2) tick();

        bus.enable = 1'b1;
        push_stream(1400);
        repeat (AW) tick();
        tick();
        check("first_run", bus.tx_data, 16'h207F);
        tick();
        check("second_run", bus.tx_data, 16'h8A18);
        repeat (10) tick();

        bus.inject = 1'b1;
        mark_inject(3);
        tick();
        bus.inject = 1'b0;
        repeat (2) tick();
        check("pending_set", bus.inject_pending, 1'b1);
        repeat (4) tick();
        check("pending_clr", bus.inject_pending, 1'b0);
        check("inj_count_one", bus.inj_count, exp_inj);

        repeat (255) begin
            bus.inject = 1'b1;
            mark_inject(3);
            tick();
            bus.inject = 1'b0;
            repeat (3) tick();
        end
        repeat (6) tick();
        check("inj_count_model", bus.inj_count, exp_inj);
        check("inj_wrap", bus.inj_count, 8'd0);

        bus.enable = 1'b0;
        exp_q.delete();
        push_idle(3);
        repeat (3) tick();
        bus.enable = 1'b1;
        push_stream(40);
        repeat (AW) tick();
        tick();
        check("restart_run", bus.tx_data, 16'h207F);
        repeat (3) tick();

        bus.enable = 1'b0;
        exp_q.delete();
        push_idle(20);
        repeat (3) begin
            bus.inject = 1'b1;
            tick();
            bus.inject = 1'b0;
            tick();
        end
        repeat (3) tick();
        check("idle_pending", bus.inject_pending, 1'b1);
        check("idle_inj_count", bus.inj_count, exp_inj);
        bus.enable = 1'b1;
        exp_q.delete();
        push_stream(40);
        mark_inject(0);
        repeat (AW) tick();
        tick();
        check("merged_first_run", bus.tx_data, 16'h207E);
        check("merged_pending_clr", bus.inject_pending, 1'b0);
        repeat (2) tick();
        check("merged_inj_count", bus.inj_count, exp_inj);

        bus.enable = 1'b0;
        exp_q.delete();
        push_idle(2);
        repeat (2) tick();
        bus.enable = 1'b1;
        push_stream(40);
        bus.inject = 1'b1;
        mark_inject(3);
        tick();
        bus.inject = 1'b0;
        repeat (AW - 1) tick();
        tick();
        check("align_inj_run", bus.tx_data, 16'h207E);
        repeat (3) tick();
        check("align_inj_count", bus.inj_count, exp_inj);

        for (int n = 0; n < 20; n++) begin
            tick();
            if (bus.state_status == 2'b10 && bus.tx_charisk == 2'b01) break;
        end
        check("comma_seen", bus.tx_charisk, 2'b01);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_data", bus.tx_data, 16'h0000);
        check("async_charisk", bus.tx_charisk, 2'b00);
        check("async_status", bus.state_status, 2'b00);
        check("async_inj_count", bus.inj_count, 8'd0);
        check("async_pending", bus.inject_pending, 1'b0);

        bus.enable = 1'b0;
        exp_q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        push_idle(2);
        repeat (2) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
